// File: rtl/irq_source_ctrl.sv
// irq_source_ctrl: synchronizes external interrupt sources, latches their
// rising edges as pending, and issues one prioritized request at a time to
// the core. It holds the request until trap entry is acknowledged and waits
// for return-from-trap before it re-arms.
module irq_source_ctrl #(
  parameter int NUM_SRC = 4,
  parameter int ID_W    = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_SRC-1:0] src_i,
  input  logic [NUM_SRC-1:0] src_en,
  input  logic               irq_ack,
  input  logic               irq_done,
  output logic               interrupt_sig,
  output logic [ID_W-1:0]    irq_id,
  output logic [NUM_SRC-1:0] pending,
  output logic [7:0]         irq_count
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    SERVICE = 2'd2
  } state_t;

  // Lowest set index wins; an all-zero input maps to index 0.
  function automatic logic [ID_W-1:0] pick_lowest(input logic [NUM_SRC-1:0] req);
    logic [ID_W-1:0] idx;
    logic            found;
    idx   = {ID_W{1'b0}};
    found = 1'b0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (req[i] && !found) begin
        idx   = ID_W'(i);
        found = 1'b1;
      end else begin
        found = found;
      end
    end
    return idx;
  endfunction

  logic [NUM_SRC-1:0] sync1_r, sync2_r, prev_r;
  logic [NUM_SRC-1:0] rise_s, ready_s, clr_s;
  logic [NUM_SRC-1:0] pending_r, pending_nxt_s;
  logic [ID_W-1:0]    winner_s;
  state_t             state_r, state_nxt_s;
  logic               irq_sig_r, irq_sig_nxt_s;
  logic [ID_W-1:0]    irq_id_r, irq_id_nxt_s;
  logic [7:0]         count_r, count_nxt_s;

  // Two-flop synchronizer plus a history flop for rising-edge detection.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_r <= {NUM_SRC{1'b0}};
      sync2_r <= {NUM_SRC{1'b0}};
      prev_r  <= {NUM_SRC{1'b0}};
    end else begin
      sync1_r <= src_i;
      sync2_r <= sync1_r;
      prev_r  <= sync2_r;
    end
  end

  assign rise_s   = sync2_r & ~prev_r;
  assign ready_s  = pending_r & src_en;
  assign winner_s = pick_lowest(ready_s);

  // Next-state and next-output logic; the ack clear is applied before new
  // edges are OR-ed in, so an edge arriving with the ack keeps the bit set.
  always_comb begin
    state_nxt_s   = state_r;
    irq_sig_nxt_s = irq_sig_r;
    irq_id_nxt_s  = irq_id_r;
    count_nxt_s   = count_r;
    clr_s         = {NUM_SRC{1'b0}};
    case (state_r)
      IDLE: begin
        if (ready_s != {NUM_SRC{1'b0}}) begin
          irq_id_nxt_s  = winner_s;
          irq_sig_nxt_s = 1'b1;
          state_nxt_s   = REQ;
        end else begin
          irq_sig_nxt_s = 1'b0;
          state_nxt_s   = IDLE;
        end
      end
      REQ: begin
        if (irq_ack) begin
          clr_s         = {{(NUM_SRC-1){1'b0}}, 1'b1} << irq_id_r;
          count_nxt_s   = count_r + 8'd1;
          irq_sig_nxt_s = 1'b0;
          state_nxt_s   = SERVICE;
        end else if (!src_en[irq_id_r]) begin
          irq_sig_nxt_s = 1'b0;
          state_nxt_s   = IDLE;
        end else begin
          irq_sig_nxt_s = 1'b1;
          state_nxt_s   = REQ;
        end
      end
      SERVICE: begin
        irq_sig_nxt_s = 1'b0;
        if (irq_done) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = SERVICE;
        end
      end
      default: begin
        irq_sig_nxt_s = 1'b0;
        state_nxt_s   = IDLE;
      end
    endcase
    pending_nxt_s = (pending_r & ~clr_s) | rise_s;
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Registered outputs: request, id, pending bits and ack counter.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      irq_sig_r <= 1'b0;
      irq_id_r  <= {ID_W{1'b0}};
      pending_r <= {NUM_SRC{1'b0}};
      count_r   <= 8'd0;
    end else begin
      irq_sig_r <= irq_sig_nxt_s;
      irq_id_r  <= irq_id_nxt_s;
      pending_r <= pending_nxt_s;
      count_r   <= count_nxt_s;
    end
  end

  assign interrupt_sig = irq_sig_r;
  assign irq_id        = irq_id_r;
  assign pending       = pending_r;
  assign irq_count     = count_r;

endmodule

// File: tb/tb_irq_source_ctrl.sv
// Directed testbench for irq_source_ctrl with hand-computed expectations.
module tb_irq_source_ctrl;

  logic       clk;
  logic       rst;
  logic [3:0] src_i;
  logic [3:0] src_en;
  logic       irq_ack;
  logic       irq_done;
  logic       interrupt_sig;
  logic [1:0] irq_id;
  logic [3:0] pending;
  logic [7:0] irq_count;

  int vectors;
  int miscompares;

  irq_source_ctrl #(.NUM_SRC(4), .ID_W(2)) dut (
    .clk           (clk),
    .rst           (rst),
    .src_i         (src_i),
    .src_en        (src_en),
    .irq_ack       (irq_ack),
    .irq_done      (irq_done),
    .interrupt_sig (interrupt_sig),
    .irq_id        (irq_id),
    .pending       (pending),
    .irq_count     (irq_count)
  );

  // 100 MHz clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hard time limit so the run always ends.
  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached, required finish before 400000");
    $fatal(1, "watchdog");
  end

  // Advance n rising edges, landing 1 time unit after the last edge.
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset;
    rst = 1'b0; src_i = 4'h0; src_en = 4'h0; irq_ack = 1'b0; irq_done = 1'b0;
    #2;
    vectors++; if (interrupt_sig !== 1'b0) begin miscompares++; $display("FAIL reset_sig: got %b want 0", interrupt_sig); end
    vectors++; if (irq_id !== 2'd0) begin miscompares++; $display("FAIL reset_id: got %0d want 0", irq_id); end
    vectors++; if (pending !== 4'h0) begin miscompares++; $display("FAIL reset_pending: got %b want 0000", pending); end
    vectors++; if (irq_count !== 8'd0) begin miscompares++; $display("FAIL reset_count: got %0d want 0", irq_count); end
    step(2);
    rst = 1'b1;
    step(2);
    vectors++; if (interrupt_sig !== 1'b0) begin miscompares++; $display("FAIL idle_sig: got %b want 0", interrupt_sig); end
  endtask

  task automatic test_single;
    src_en = 4'hF; src_i = 4'b0100;
    step(2);  // edges k, k+1
    vectors++; if (pending !== 4'h0) begin miscompares++; $display("FAIL single_pend_early: got %b want 0000", pending); end
    step(1);  // edge k+2
    vectors++; if (pending !== 4'b0100) begin miscompares++; $display("FAIL single_pend: got %b want 0100", pending); end
    vectors++; if (interrupt_sig !== 1'b0) begin miscompares++; $display("FAIL single_sig_early: got %b want 0", interrupt_sig); end
    step(1);  // edge k+3
    vectors++; if (interrupt_sig !== 1'b1) begin miscompares++; $display("FAIL single_sig: got %b want 1", interrupt_sig); end
    vectors++; if (irq_id !== 2'd2) begin miscompares++; $display("FAIL single_id: got %0d want 2", irq_id); end
    irq_ack = 1'b1; step(1); irq_ack = 1'b0;
    vectors++; if (interrupt_sig !== 1'b0) begin miscompares++; $display("FAIL single_ack_sig: got %b want 0", interrupt_sig); end
    vectors++; if (pending !== 4'h0) begin miscompares++; $display("FAIL single_ack_pend: got %b want 0000", pending); end
    vectors++; if (irq_count !== 8'd1) begin miscompares++; $display("FAIL single_count: got %0d want 1", irq_count); end
    step(2);
    vectors++; if (irq_id !== 2'd2) begin miscompares++; $display("FAIL single_service_id: got %0d want 2", irq_id); end
    irq_done = 1'b1; step(1); irq_done = 1'b0;
    src_i = 4'h0;
    step(4);
    vectors++; if (interrupt_sig !== 1'b0) begin miscompares++; $display("FAIL single_after_done: got %b want 0", interrupt_sig); end
  endtask

  task automatic test_priority;
    src_i = 4'b1010;
    step(4);
    vectors++; if (interrupt_sig !== 1'b1 || irq_id !== 2'd1) begin miscompares++; $display("FAIL prio_first: got sig=%b id=%0d want sig=1 id=1", interrupt_sig, irq_id); end
    src_i = 4'b1011;
    step(3);
    vectors++; if (pending !== 4'b1011) begin miscompares++; $display("FAIL prio_pend: got %b want 1011", pending); end
    step(1);
    vectors++; if (interrupt_sig !== 1'b1 || irq_id !== 2'd1) begin miscompares++; $display("FAIL prio_frozen: got sig=%b id=%0d want sig=1 id=1", interrupt_sig, irq_id); end
    irq_ack = 1'b1; step(1); irq_ack = 1'b0;
    vectors++; if (pending !== 4'b1001 || irq_count !== 8'd2) begin miscompares++; $display("FAIL prio_ack1: got pend=%b cnt=%0d want pend=1001 cnt=2", pending, irq_count); end
    step(2);
    vectors++; if (interrupt_sig !== 1'b0) begin miscompares++; $display("FAIL prio_service_low: got %b want 0", interrupt_sig); end
    irq_done = 1'b1; step(1); irq_done = 1'b0;  // edge d
    vectors++; if (interrupt_sig !== 1'b0) begin miscompares++; $display("FAIL prio_rearm_gap: got %b want 0", interrupt_sig); end
    step(1);  // edge d+1
    vectors++; if (interrupt_sig !== 1'b1 || irq_id !== 2'd0) begin miscompares++; $display("FAIL prio_second: got sig=%b id=%0d want sig=1 id=0", interrupt_sig, irq_id); end
    irq_ack = 1'b1; step(1); irq_ack = 1'b0;
    vectors++; if (pending !== 4'b1000 || irq_count !== 8'd3) begin miscompares++; $display("FAIL prio_ack2: got pend=%b cnt=%0d want pend=1000 cnt=3", pending, irq_count); end
    irq_done = 1'b1; step(1); irq_done = 1'b0;
    step(1);
    vectors++; if (interrupt_sig !== 1'b1 || irq_id !== 2'd3) begin miscompares++; $display("FAIL prio_third: got sig=%b id=%0d want sig=1 id=3", interrupt_sig, irq_id); end
    irq_ack = 1'b1; step(1); irq_ack = 1'b0;
    vectors++; if (pending !== 4'b0000 || irq_count !== 8'd4) begin miscompares++; $display("FAIL prio_ack3: got pend=%b cnt=%0d want pend=0000 cnt=4", pending, irq_count); end
    irq_done = 1'b1; step(1); irq_done = 1'b0;
    src_i = 4'h0;
    step(4);
  endtask

  task automatic test_masking;
    src_en = 4'b1110; src_i = 4'b0001;
    step(3);
    vectors++; if (pending !== 4'b0001) begin miscompares++; $display("FAIL mask_pend: got %b want 0001", pending); end
    step(3);
    vectors++; if (interrupt_sig !== 1'b0) begin miscompares++; $display("FAIL mask_sig: got %b want 0", interrupt_sig); end
    // A stray ack outside REQ must not count.
    irq_ack = 1'b1; step(1); irq_ack = 1'b0;
    vectors++; if (irq_count !== 8'd4 || pending !== 4'b0001) begin miscompares++; $display("FAIL mask_stray_ack: got cnt=%0d pend=%b want cnt=4 pend=0001", irq_count, pending); end
    src_en = 4'hF;
    step(1);
    vectors++; if (interrupt_sig !== 1'b1 || irq_id !== 2'd0) begin miscompares++; $display("FAIL mask_enable: got sig=%b id=%0d want sig=1 id=0", interrupt_sig, irq_id); end
    irq_ack = 1'b1; step(1); irq_ack = 1'b0;
    vectors++; if (irq_count !== 8'd5) begin miscompares++; $display("FAIL mask_count: got %0d want 5", irq_count); end
    irq_done = 1'b1; step(1); irq_done = 1'b0;
    src_i = 4'h0;
    step(4);
  endtask

  task automatic test_withdraw;
    src_i = 4'b0100;
    step(4);
    vectors++; if (interrupt_sig !== 1'b1 || irq_id !== 2'd2) begin miscompares++; $display("FAIL wd_req: got sig=%b id=%0d want sig=1 id=2", interrupt_sig, irq_id); end
    src_en = 4'b1011;
    step(1);  // edge w
    vectors++; if (interrupt_sig !== 1'b0) begin miscompares++; $display("FAIL wd_sig: got %b want 0", interrupt_sig); end
    vectors++; if (pending !== 4'b0100 || irq_count !== 8'd5) begin miscompares++; $display("FAIL wd_keep: got pend=%b cnt=%0d want pend=0100 cnt=5", pending, irq_count); end
    src_en = 4'hF;
    step(1);
    vectors++; if (interrupt_sig !== 1'b1 || irq_id !== 2'd2) begin miscompares++; $display("FAIL wd_rereq: got sig=%b id=%0d want sig=1 id=2", interrupt_sig, irq_id); end
    // Ack together with mask removal: ack is taken.
    src_en = 4'b1011; irq_ack = 1'b1;
    step(1);
    irq_ack = 1'b0; src_en = 4'hF;
    vectors++; if (interrupt_sig !== 1'b0 || irq_count !== 8'd6 || pending !== 4'b0000) begin miscompares++; $display("FAIL wd_ack_mask: got sig=%b cnt=%0d pend=%b want sig=0 cnt=6 pend=0000", interrupt_sig, irq_count, pending); end
    irq_done = 1'b1; step(1); irq_done = 1'b0;
    src_i = 4'h0;
    step(4);
  endtask

  task automatic test_back_to_back;
    src_i = 4'b0100;
    step(4);
    vectors++; if (interrupt_sig !== 1'b1 || irq_id !== 2'd2) begin miscompares++; $display("FAIL b2b_req: got sig=%b id=%0d want sig=1 id=2", interrupt_sig, irq_id); end
    src_i = 4'h0;
    step(3);
    src_i = 4'b0100;
    step(2);  // edges k', k'+1; the new edge lands at k'+2
    irq_ack = 1'b1; step(1); irq_ack = 1'b0;
    vectors++; if (pending !== 4'b0100 || irq_count !== 8'd7) begin miscompares++; $display("FAIL b2b_set_wins: got pend=%b cnt=%0d want pend=0100 cnt=7", pending, irq_count); end
    irq_done = 1'b1; step(1); irq_done = 1'b0;
    step(1);
    vectors++; if (interrupt_sig !== 1'b1 || irq_id !== 2'd2) begin miscompares++; $display("FAIL b2b_redeliver: got sig=%b id=%0d want sig=1 id=2", interrupt_sig, irq_id); end
    irq_ack = 1'b1; step(1); irq_ack = 1'b0;
    vectors++; if (pending !== 4'b0000 || irq_count !== 8'd8) begin miscompares++; $display("FAIL b2b_ack2: got pend=%b cnt=%0d want pend=0000 cnt=8", pending, irq_count); end
    irq_done = 1'b1; step(1); irq_done = 1'b0;
    src_i = 4'h0;
    step(4);
  endtask

  task automatic test_reset_mid;
    src_i = 4'b0011;
    step(4);
    vectors++; if (interrupt_sig !== 1'b1 || pending !== 4'b0011) begin miscompares++; $display("FAIL rmid_setup: got sig=%b pend=%b want sig=1 pend=0011", interrupt_sig, pending); end
    rst = 1'b0; src_i = 4'h0;
    #1;
    vectors++; if (interrupt_sig !== 1'b0 || irq_id !== 2'd0 || pending !== 4'h0 || irq_count !== 8'd0) begin miscompares++; $display("FAIL rmid_async: got sig=%b id=%0d pend=%b cnt=%0d want all 0", interrupt_sig, irq_id, pending, irq_count); end
    step(2);
    rst = 1'b1;
    step(6);
    vectors++; if (interrupt_sig !== 1'b0 || pending !== 4'h0) begin miscompares++; $display("FAIL rmid_after: got sig=%b pend=%b want sig=0 pend=0000", interrupt_sig, pending); end
  endtask

  task automatic test_wrap;
    int lost;
    bit seen;
    lost = 0;
    for (int i = 0; i < 256; i++) begin
      src_i = 4'b0001;
      seen = 1'b0;
      for (int t = 0; t < 8 && !seen; t++) begin
        step(1);
        if (interrupt_sig === 1'b1 && irq_id === 2'd0) seen = 1'b1;
      end
      if (!seen) lost++;
      irq_ack = 1'b1; step(1); irq_ack = 1'b0;
      if (i == 254) begin
        vectors++; if (irq_count !== 8'd255) begin miscompares++; $display("FAIL wrap_255: got %0d want 255", irq_count); end
      end
      if (i == 255) begin
        vectors++; if (irq_count !== 8'd0) begin miscompares++; $display("FAIL wrap_0: got %0d want 0", irq_count); end
      end
      irq_done = 1'b1; step(1); irq_done = 1'b0;
      src_i = 4'h0;
      step(3);
    end
    vectors++; if (lost !== 0) begin miscompares++; $display("FAIL wrap_lost: got %0d lost requests want 0", lost); end
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    test_reset();
    test_single();
    test_priority();
    test_masking();
    test_withdraw();
    test_back_to_back();
    test_reset_mid();
    test_wrap();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/irq_source_ctrl.md
# irq_source_ctrl

Interrupt requester that drives the core's `interrupt_sig` input and answers its trap handshake. It synchronizes up to NUM_SRC asynchronous external sources, latches their rising edges as pending, and presents the highest-priority enabled request to the core. The request is held until the core acknowledges trap entry, and the block waits for the core's return-from-trap before it issues the next request. It sits between board-level event lines and the `main` core, replacing the bench-driven raw `interrupt_sig` pulse.

## Interface
- NUM_SRC, 4, number of external interrupt sources (2..16).
- ID_W, 2, width of `irq_id`; must satisfy 2^ID_W >= NUM_SRC.
- clk  in  1  system clock, rising-edge active.
- rst  in  1  asynchronous, active-low reset (0 = reset).
- src_i  in  NUM_SRC  raw source lines, asynchronous to clk.
- src_en  in  NUM_SRC  per-source enable mask, synchronous to clk.
- irq_ack  in  1  one-cycle pulse from the core on trap entry.
- irq_done  in  1  one-cycle pulse from the core on return from trap (mret).
- interrupt_sig  out  1  interrupt request to the core, registered.
- irq_id  out  ID_W  index of the source being requested or serviced.
- pending  out  NUM_SRC  latched pending bits.
- irq_count  out  8  number of acknowledged interrupts, modulo 256.

## Operation
- Each `src_i` bit passes through a two-flop synchronizer, followed by a third flop for edge detection. A rising edge, meaning the synchronized value is 1 and the previous value was 0, sets `pending[i]`.
- A source that is already high when reset is released produces exactly one edge.
- `pending` bits are set regardless of `src_en`. A masked pending bit stays latched and is delivered once it is enabled.
- Priority: the lowest index among `pending & src_en` wins.
- FSM states are IDLE, REQ and SERVICE.
  - IDLE: if `pending & src_en` is non-zero, latch the winner into `irq_id`, set `interrupt_sig`=1 and go to REQ. Otherwise stay.
  - REQ: hold `interrupt_sig`=1 and hold `irq_id`. Priority is frozen, so a higher-priority arrival does not preempt.
    - On `irq_ack`: clear `pending[irq_id]`, increment `irq_count`, set `interrupt_sig`=0 and go to SERVICE.
    - If `src_en[irq_id]`=0 and `irq_ack`=0: withdraw. Set `interrupt_sig`=0, go to IDLE, and keep the pending bit.
  - SERVICE: `interrupt_sig`=0 and `irq_id` is held. On `irq_done`, go to IDLE.
- Simultaneous events:
  - `irq_ack` together with mask removal: the ack wins.
  - A new edge on `irq_id` in the same cycle as the ack clear: the set wins, and the bit stays pending.
  - `irq_ack` outside REQ is ignored. `irq_done` outside SERVICE is ignored.
- `irq_count` wraps from 255 to 0.

## Timing
- Reset (rst=0) forces the following immediately and asynchronously: `interrupt_sig`=0, `irq_id`=0, `pending`=0, `irq_count`=0, all synchronizer and edge flops cleared, FSM=IDLE.
- Reset asserted mid-REQ or mid-SERVICE drops the request immediately and discards all pending edges.
- Source latency: `src_i` is first sampled high at edge k.
  - `pending[i]` becomes 1 after edge k+2.
  - `interrupt_sig` becomes 1 after edge k+3 if the FSM is in IDLE and the source is enabled.
- Ack latency: `irq_ack` is sampled at edge m.
  - `interrupt_sig`=0, the pending bit clears and `irq_count` increments, all after edge m.
- Re-arm gap: `irq_done` is sampled at edge d.
  - The FSM is in IDLE after edge d.
  - The earliest next `interrupt_sig` rise is after edge d+1, so there is at least one low cycle between requests.
- Withdraw: `src_en[irq_id]` falls at edge w during REQ, and `interrupt_sig`=0 after edge w.
- All outputs are registered, with no combinational path from inputs to outputs.

## Test plan
- Single source:
  - Stimulus: `src_i`=4'b0100 and `src_en`=4'hF, then `irq_ack`, then `irq_done`.
  - Response: `pending`=4'b0100, then `interrupt_sig`=1 with `irq_id`=2 three edges after first sampling. After the ack, `interrupt_sig`=0, `pending`=0 and `irq_count`=1.
- Priority and freeze:
  - Stimulus: sources 3 and 1 rise together; source 0 rises during REQ.
  - Response: `irq_id`=1 is requested and held until ack, not preempted by source 0. After `irq_done`, source 0 is served, then source 3.
- Masking:
  - Stimulus: `src_en`=4'b1110 with source 0 edge.
  - Response: `pending[0]`=1 and `interrupt_sig` stays 0. Setting `src_en[0]`=1 raises `interrupt_sig` after the next edge with `irq_id`=0.
- Withdraw and simultaneity:
  - Clearing `src_en[2]` during REQ on id 2: `interrupt_sig` falls, `pending[2]` stays 1 and the count is unchanged.
  - Ack coincident with mask removal: the ack is taken and the count increments.
  - New edge coincident with ack: the bit remains pending.
- Reset mid-operation:
  - Stimulus: rst=0 while in REQ with two bits pending, released two cycles later with `src_i`=0.
  - Response: all outputs 0 immediately, and no request after release.
- Counter wrap:
  - Stimulus: 256 ack/done cycles on source 0.
  - Response: `irq_count` reads 255, then 0, with no lost requests.
